writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Parametrised MEM/WB pipeline register and result selector for the RISC-V pipeline. It takes up to NUM_SRC result sources and selects one, with load-data alignment and sign/zero extension applied to the memory source. The selected result is latched with valid, stall and flush control, and x0 writes are suppressed. A wrapping retired-instruction counter is also kept. Its outputs drive the register-file write port and the forwarding unit.

Parameters:
XLEN, 32, datapath width in bits; must be ≥ 32.
NUM_SRC, 4, number of result sources (0 = ALU, 1 = load data, 2 = PC+4, 3 = CSR by convention); range 2..8.
SEL_W, 2, width of result select; must satisfy 2^SEL_W ≥ NUM_SRC.
LOAD_SRC, 1, source index that receives load alignment and extension.
REG_AW, 5, register address width.
CNT_W, 32, retired-instruction counter width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset (asserted at 0).
valid_m  in  1  MEM stage holds a valid instruction.
rd_m  in  REG_AW  destination register.
reg_write_m  in  1  instruction writes rd.
result_sel_m  in  SEL_W  source index.
src_data_m  in  NUM_SRC*XLEN  packed sources; source i occupies bits [i*XLEN +: XLEN].
load_size_m  in  2  00 = byte, 01 = half, 10 = word, 11 = word.
load_unsigned_m  in  1  1 = zero-extend, 0 = sign-extend.
byte_off_m  in  2  low address bits of the load.
stall_w  in  1  hold the WB register.
flush_w  in  1  kill the instruction entering WB.
valid_w  out  1  WB holds a valid instruction.
reg_write_w  out  1  register-file write enable.
rd_w  out  REG_AW  write address.
result_w  out  XLEN  write data.
retired_cnt  out  CNT_W  count of instructions accepted into WB.

Behaviour:
- Reset (rst = 0, asynchronous): all outputs 0 immediately. An assertion mid-operation discards the held instruction and clears the counter. Deassertion takes effect at the next rising edge.
- Latency: one cycle from MEM inputs to WB outputs. There is no combinational path from inputs to outputs.
- Priority each edge is flush_w > stall_w > normal capture.
- flush_w = 1: valid_w ← 0, reg_write_w ← 0, rd_w ← 0, result_w ← 0. The counter does not increment. This applies even when stall_w = 1 in the same cycle.
- stall_w = 1 without flush: every output register holds its value, including the counter.
- Normal capture (no flush, no stall), with accept = valid_m:
  - valid_w ← valid_m.
  - rd_w ← rd_m.
  - reg_write_w ← valid_m & reg_write_m & (rd_m ≠ 0).
  - result_w ← selected value if the new reg_write_w = 1, else 0.
  - retired_cnt ← retired_cnt + 1 when accept; wraps modulo 2^CNT_W with no saturation.
- Selection:
  - If result_sel_m ≥ NUM_SRC, the selected value is 0.
  - Any index other than LOAD_SRC passes source data unchanged.
- Load path (index = LOAD_SRC), with w = low 32 bits of the source:
  - Byte: b = w[8*byte_off_m +: 8]; extended to XLEN.
  - Half: h = w[16*byte_off_m[1] +: 16]; byte_off_m[0] is ignored (misalignment is trapped upstream); extended to XLEN.
  - Word: w, extended to XLEN (only relevant when XLEN > 32).
  - Extension: sign-extend from the top bit when load_unsigned_m = 0, zero-extend when 1.
- valid_m = 0 during normal capture: a bubble. valid_w = 0, reg_write_w = 0, result_w = 0, counter unchanged.

Test Plan:
- Reset release, then ALU source with src0 = 0x0000_1234, rd = 5, reg_write = 1 → next cycle valid_w = 1, reg_write_w = 1, rd_w = 5, result_w = 0x0000_1234, retired_cnt = 1. Asserting rst low mid-stream zeroes all outputs without waiting for a clock edge.
- Load source with src1 = 0x80FF_7F01 → required results:
  - byte, off = 1, signed → 0x0000_007F.
  - byte, off = 3, signed → 0xFFFF_FF80.
  - half, off = 2, unsigned → 0x0000_80FF.
  - half, off = 2, signed → 0xFFFF_80FF.
  - word → 0x80FF_7F01.
- rd_m = 0 with reg_write_m = 1 and ALU result 0xDEAD_BEEF → reg_write_w = 0, result_w = 0, valid_w = 1, counter increments.
- PC+4 source 0x0000_0104 latched, then stall_w = 1 for 3 cycles while inputs change → outputs and counter frozen at the PC+4 values. On stall release the new inputs are captured.
- flush_w = 1 together with stall_w = 1 and a valid instruction → valid_w = 0, reg_write_w = 0, result_w = 0, counter unchanged.
- result_sel = 3 with NUM_SRC = 3 → result_w = 0. Counter preset via 2^CNT_W − 1 accepted instructions (CNT_W = 4: 15) plus one more → retired_cnt wraps to 0.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB pipeline register and result selector.
// Selects one of NUM_SRC packed result sources. The LOAD_SRC source is
// aligned and extended as load data. The result is registered with
// flush > stall > capture priority. Writes to x0 are suppressed, and a
// wrapping count of accepted instructions is kept.
// Ports:
//   clk, rst (async, active-low)
//   MEM side : valid_m, rd_m, reg_write_m, result_sel_m, src_data_m,
//              load_size_m, load_unsigned_m, byte_off_m
//   control  : stall_w, flush_w
//   WB side  : valid_w, reg_write_w, rd_w, result_w, retired_cnt
//              (all registered)
module writeback_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned LOAD_SRC = 1,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_m,
  input  logic [REG_AW-1:0]       rd_m,
  input  logic                    reg_write_m,
  input  logic [SEL_W-1:0]        result_sel_m,
  input  logic [NUM_SRC*XLEN-1:0] src_data_m,
  input  logic [1:0]              load_size_m,
  input  logic                    load_unsigned_m,
  input  logic [1:0]              byte_off_m,
  input  logic                    stall_w,
  input  logic                    flush_w,
  output logic                    valid_w,
  output logic                    reg_write_w,
  output logic [REG_AW-1:0]       rd_w,
  output logic [XLEN-1:0]         result_w,
  output logic [CNT_W-1:0]        retired_cnt
);

  localparam int unsigned WORD_W = 32;

  logic [WORD_W-1:0] w_load_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_data;
  logic [XLEN-1:0]   w_sel_data;
  logic              w_wr_en;

  logic              r_valid;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_result;
  logic [CNT_W-1:0]  r_cnt;

  // Low word of the load source. An out-of-range LOAD_SRC falls back to 0,
  // but in that case the load path is never selected.
  localparam int unsigned LOAD_IDX = (LOAD_SRC < NUM_SRC) ? LOAD_SRC : 0;
  assign w_load_word = src_data_m[LOAD_IDX*XLEN +: WORD_W];

  // Load alignment: the byte lane comes from the full offset, and the
  // halfword lane comes from offset bit 1 only.
  always_comb begin
    w_byte = 8'h00;
    case (byte_off_m)
      2'd0:    w_byte = w_load_word[7:0];
      2'd1:    w_byte = w_load_word[15:8];
      2'd2:    w_byte = w_load_word[23:16];
      default: w_byte = w_load_word[31:24];
    endcase
    w_half = byte_off_m[1] ? w_load_word[31:16] : w_load_word[15:0];
  end

  // Fill with the extension bit first, then overlay the loaded field.
  always_comb begin
    w_load_data = '0;
    case (load_size_m)
      2'b00: begin
        w_load_data       = {XLEN{~load_unsigned_m & w_byte[7]}};
        w_load_data[7:0]  = w_byte;
      end
      2'b01: begin
        w_load_data       = {XLEN{~load_unsigned_m & w_half[15]}};
        w_load_data[15:0] = w_half;
      end
      default: begin
        w_load_data       = {XLEN{~load_unsigned_m & w_load_word[WORD_W-1]}};
        w_load_data[WORD_W-1:0] = w_load_word;
      end
    endcase
  end

  // Result mux. An index with no matching source selects zero.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (result_sel_m == SEL_W'(i)) begin
        w_sel_data = (i == LOAD_SRC) ? w_load_data : src_data_m[i*XLEN +: XLEN];
      end
    end
  end

  assign w_wr_en = valid_m & reg_write_m & (rd_m != '0);

  // WB register: flush beats stall, and stall beats capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
    end else if (flush_w) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
    end else if (!stall_w) begin
      r_valid     <= valid_m;
      r_reg_write <= w_wr_en;
      r_rd        <= rd_m;
      r_result    <= w_wr_en ? w_sel_data : '0;
      if (valid_m) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_w     = r_valid;
  assign reg_write_w = r_reg_write;
  assign rd_w        = r_rd;
  assign result_w    = r_result;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit. It uses a 3-source, 4-bit-counter
// configuration, so that the out-of-range select and the counter wrap
// can both be reached.
module tb_writeback_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CNT_W   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_m;
  logic [REG_AW-1:0]       rd_m;
  logic                    reg_write_m;
  logic [SEL_W-1:0]        result_sel_m;
  logic [NUM_SRC*XLEN-1:0] src_data_m;
  logic [1:0]              load_size_m;
  logic                    load_unsigned_m;
  logic [1:0]              byte_off_m;
  logic                    stall_w;
  logic                    flush_w;
  logic                    valid_w;
  logic                    reg_write_w;
  logic [REG_AW-1:0]       rd_w;
  logic [XLEN-1:0]         result_w;
  logic [CNT_W-1:0]        retired_cnt;

  int n_cmp = 0;
  int n_err = 0;

  writeback_unit #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .LOAD_SRC(1),
    .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .rd_m(rd_m),
    .reg_write_m(reg_write_m), .result_sel_m(result_sel_m),
    .src_data_m(src_data_m), .load_size_m(load_size_m),
    .load_unsigned_m(load_unsigned_m), .byte_off_m(byte_off_m),
    .stall_w(stall_w), .flush_w(flush_w), .valid_w(valid_w),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [4:0]  rd;
    bit        we;
    bit [1:0]  sel;
    bit [31:0] s0, s1, s2;
    bit [1:0]  size;
    bit        uns;
    bit [1:0]  off;
    bit        stall, flush;
    bit        e_v, e_we;
    bit [4:0]  e_rd;
    bit [31:0] e_res;
    bit [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input bit v, input bit we, input bit [4:0] rd,
                         input bit [31:0] res, input bit [3:0] cnt);
    chk({tag, ".valid_w"},     64'(valid_w),     64'(v));
    chk({tag, ".reg_write_w"}, 64'(reg_write_w), 64'(we));
    chk({tag, ".rd_w"},        64'(rd_w),        64'(rd));
    chk({tag, ".result_w"},    64'(result_w),    64'(res));
    chk({tag, ".retired_cnt"}, 64'(retired_cnt), 64'(cnt));
  endtask

  task automatic drive(input bit v, input bit [4:0] rd, input bit we, input bit [1:0] sel,
                       input bit [31:0] s0, input bit [31:0] s1, input bit [31:0] s2,
                       input bit [1:0] size, input bit uns, input bit [1:0] off,
                       input bit stall, input bit flush);
    valid_m = v; rd_m = rd; reg_write_m = we; result_sel_m = sel;
    src_data_m = {s2, s1, s0};
    load_size_m = size; load_unsigned_m = uns; byte_off_m = off;
    stall_w = stall; flush_w = flush;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse, issued away from the clock edge.
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  // Reference: the written value follows from the load rules, using shifts and modular arithmetic.
  function automatic bit [31:0] ref_value(input int sel, input bit [31:0] s0, input bit [31:0] s1,
                                          input bit [31:0] s2, input int size, input bit uns,
                                          input int off);
    longint v;
    longint width;
    case (sel)
      0: return s0;
      2: return s2;
      1: begin
        if (size == 0) begin
          width = 8;
          v = (longint'(s1) >> (8 * off)) % 256;
        end else if (size == 1) begin
          width = 16;
          v = (longint'(s1) >> (16 * (off / 2))) % 65536;
        end else begin
          return s1;
        end
        if (!uns && v >= (longint'(1) << (width - 1))) v = v + (longint'(1) << 32) - (longint'(1) << width);
        return 32'(v);
      end
      default: return 32'h0;
    endcase
  endfunction

  bit        m_v, m_we;
  bit [4:0]  m_rd;
  bit [31:0] m_res;
  int        m_cnt;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    #10 rst = 1'b1;

    // valid rd we sel s0 s1 s2 size uns off stall flush | e_v e_we e_rd e_res e_cnt
    vecs[0]  = '{1, 5,  1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5,  32'h0000_1234, 1};
    vecs[1]  = '{1, 6,  1, 1, 0, 32'h80FF_7F01, 0, 0, 0, 1, 0, 0, 1, 1, 6,  32'h0000_007F, 2};
    vecs[2]  = '{1, 6,  1, 1, 0, 32'h80FF_7F01, 0, 0, 0, 3, 0, 0, 1, 1, 6,  32'hFFFF_FF80, 3};
    vecs[3]  = '{1, 6,  1, 1, 0, 32'h80FF_7F01, 0, 1, 1, 2, 0, 0, 1, 1, 6,  32'h0000_80FF, 4};
    vecs[4]  = '{1, 6,  1, 1, 0, 32'h80FF_7F01, 0, 1, 0, 2, 0, 0, 1, 1, 6,  32'hFFFF_80FF, 5};
    vecs[5]  = '{1, 6,  1, 1, 0, 32'h80FF_7F01, 0, 2, 0, 0, 0, 0, 1, 1, 6,  32'h80FF_7F01, 6};
    vecs[6]  = '{1, 0,  1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  32'h0, 7};
    vecs[7]  = '{1, 7,  1, 3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0, 0, 0, 0, 0, 1, 1, 7, 32'h0, 8};
    vecs[8]  = '{0, 9,  1, 0, 32'h4444_4444, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9,  32'h0, 8};
    vecs[9]  = '{1, 10, 1, 0, 32'h99, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  32'h0, 8};
    vecs[10] = '{1, 11, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0, 11, 32'h0, 9};
    vecs[11] = '{1, 12, 1, 1, 0, 32'h80FF_7F01, 0, 3, 1, 0, 0, 0, 1, 1, 12, 32'h80FF_7F01, 10};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].we, vecs[i].sel, vecs[i].s0, vecs[i].s1,
            vecs[i].s2, vecs[i].size, vecs[i].uns, vecs[i].off, vecs[i].stall, vecs[i].flush);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_we, vecs[i].e_rd,
              vecs[i].e_res, vecs[i].e_cnt);
    end

    // A mid-stream reset clears the outputs without a clock edge.
    #3 rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    #2 rst = 1'b1;

    // Stall: PC+4 is captured, then held for 3 cycles while the inputs change.
    drive(1, 1, 1, 2, 0, 0, 32'h0000_0104, 0, 0, 0, 0, 0);
    step();
    chk_all("pc4", 1, 1, 1, 32'h104, 1);
    drive(1, 3, 1, 0, 32'h0000_AAAA, 0, 32'h0000_0BAD, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("stall%0d", i), 1, 1, 1, 32'h104, 1);
    end
    stall_w = 1'b0;
    step();
    chk_all("stall_rel", 1, 1, 3, 32'h0000_AAAA, 2);

    // Counter wrap at 2^CNT_W accepted instructions.
    pulse_reset();
    drive(1, 4, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 14) chk("cnt_15", 64'(retired_cnt), 64'd15);
      if (i == 15) chk("cnt_wrap", 64'(retired_cnt), 64'd0);
    end

    // Random traffic against the reference model.
    pulse_reset();
    m_v = 0; m_we = 0; m_rd = 0; m_res = 0; m_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      bit        v, we, uns, st, fl;
      bit [4:0]  rd;
      bit [1:0]  sel, size, off;
      bit [31:0] s0, s1, s2;
      v = 1'($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 31));
      sel = 2'($urandom_range(0, 3));
      s0 = $urandom; s1 = $urandom; s2 = $urandom;
      size = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      st = 1'($urandom_range(0, 4) == 0);
      fl = 1'($urandom_range(0, 9) == 0);
      drive(v, rd, we, sel, s0, s1, s2, size, uns, off, st, fl);
      step();
      if (fl) begin
        m_v = 0; m_we = 0; m_rd = 0; m_res = 0;
      end else if (!st) begin
        m_v = v;
        m_we = v && we && (rd != 0);
        m_rd = rd;
        m_res = m_we ? ref_value(int'(sel), s0, s1, s2, int'(size), uns, int'(off)) : 32'h0;
        if (v) m_cnt = (m_cnt + 1) % 16;
      end
      chk_all($sformatf("rnd%0d", n), m_v, m_we, m_rd, m_res, 4'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
